// File: rtl/mux3_pkg.sv
// Shared definitions for the 3-to-1 mux sequencer: select codes, source indices and FSM states.
package mux3_pkg;

    localparam logic [1:0] SEL_X    = 2'b00;
    localparam logic [1:0] SEL_Y    = 2'b01;
    localparam logic [1:0] SEL_Z    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [1:0] SRC_X = 2'd0;
    localparam logic [1:0] SRC_Y = 2'd1;
    localparam logic [1:0] SRC_Z = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_e;

    // Successor of a source in round-robin order, wrapping Z back to X.
    function automatic logic [1:0] next_src(input logic [1:0] src);
        return (src == SRC_Z) ? SRC_X : src + 2'd1;
    endfunction

    function automatic logic [1:0] src_to_sel(input logic [1:0] src);
        logic [1:0] code;
        case (src)
            SRC_X:   code = SEL_X;
            SRC_Y:   code = SEL_Y;
            SRC_Z:   code = SEL_Z;
            default: code = SEL_NONE;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] sel_to_src(input logic [1:0] code);
        logic [1:0] src;
        case (code)
            SEL_Y:   src = SRC_Y;
            SEL_Z:   src = SRC_Z;
            default: src = SRC_X;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/mux3_rr_sequencer_if.sv
// Request/grant/select and downstream valid/ready bundle of the mux sequencer.
interface mux3_rr_sequencer_if #(
    parameter int unsigned WIDTH = 4
);

    logic [2:0]       req;
    logic [2:0]       grant;
    logic [1:0]       sel;
    logic [WIDTH-1:0] mux_o;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  req,
        input  mux_o,
        input  out_ready,
        output grant,
        output sel,
        output out_data,
        output out_valid
    );

    modport slave (
        output req,
        output mux_o,
        output out_ready,
        input  grant,
        input  sel,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/rr_pick3.sv
// Three-way request picker: round-robin from ptr by default, fixed X>Y>Z priority when
// FIXED_PRIORITY_EN is defined.
module rr_pick3
    import mux3_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic [2:0] onehot,
    output logic       any
);

    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;

`ifdef FIXED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        first  = SRC_X;
        second = SRC_Y;
        third  = SRC_Z;
    end
`else
    // An out-of-range pointer is treated as X so the search order is always a rotation.
    always_comb begin
        first  = (ptr > SRC_Z) ? SRC_X : ptr;
        second = next_src(first);
        third  = next_src(second);
    end
`endif

    always_comb begin
        winner = first;
        if (req[first]) begin
            winner = first;
        end else if (req[second]) begin
            winner = second;
        end else if (req[third]) begin
            winner = third;
        end
    end

    assign any    = |req;
    assign onehot = any ? (3'b001 << winner) : 3'b000;

endmodule

// File: rtl/mux3_rr_sequencer.sv
// Arbitrates sources X/Y/Z onto the shared 3-to-1 mux and hands the sampled output downstream
// with valid/ready. Define FIXED_PRIORITY_EN to replace round-robin with fixed X>Y>Z priority.
module mux3_rr_sequencer
    import mux3_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    mux3_rr_sequencer_if.master bus
);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       grant_q, grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             launch;

    logic [1:0]       ptr_q;
    logic [1:0]       pick_win;
    logic [2:0]       pick_onehot;
    logic             pick_any;

    rr_pick3 u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick_win),
        .onehot (pick_onehot),
        .any    (pick_any)
    );

`ifdef FIXED_PRIORITY_EN
    assign ptr_q = SRC_X;
`else
    // In GRANT, sel_q still carries the winner's code, so the pointer moves past it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= SRC_X;
        end else if (state_q == GRANT) begin
            ptr_q <= next_src(sel_to_src(sel_q));
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = SEL_NONE;
        grant_d = 3'b000;
        data_d  = data_q;
        valid_d = valid_q;
        launch  = 1'b0;

        unique case (state_q)
            IDLE: begin
                launch = pick_any;
            end
            GRANT: begin
                data_d  = bus.mux_o;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                // Requests are only looked at once the held word has been accepted.
                if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    launch  = pick_any;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (launch) begin
            state_d = GRANT;
            sel_d   = src_to_sel(pick_win);
            grant_d = pick_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_NONE;
            grant_q <= 3'b000;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

    a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));

    a_sel_matches_grant : assert property (@(posedge clk) disable iff (!rst_n)
        (grant_q != 3'b000) == (sel_q != SEL_NONE));

    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && !bus.out_ready) |=> (valid_q && $stable(data_q)));

endmodule

// File: tb/tb_mux3_rr_sequencer.sv
// Scoreboard bench for mux3_rr_sequencer: a transaction-level model predicts grants and captured
// words with their cycle stamps; a monitor checks them as the DUT presents them.
module tb_mux3_rr_sequencer;
    import mux3_pkg::*;

    localparam int unsigned WIDTH = 4;

    typedef struct {
        int cyc;
        int src;
    } gexp_t;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] data;
    } dexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux3_rr_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mux3_rr_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH-1:0] src_data [3];

    // Behavioural mux: select code picks a source word, 11 drives zero.
    always_comb begin
        case (bus.sel)
            2'b00:   bus.mux_o = src_data[0];
            2'b01:   bus.mux_o = src_data[1];
            2'b10:   bus.mux_o = src_data[2];
            default: bus.mux_o = '0;
        endcase
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    gexp_t gq[$];
    dexp_t dq[$];

    // Model state: 0 free, 1 granting m_src this cycle, 2 holding a word for downstream.
    int m_phase;
    int m_ptr;
    int m_src;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int p);
        int start;
`ifdef FIXED_PRIORITY_EN
        start = 0;
`else
        start = p;
`endif
        for (int k = 0; k < 3; k++) begin
            if (r[(start + k) % 3]) return (start + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_src   = 0;
        gq.delete();
        dq.delete();
    endtask

    task automatic model_launch(input logic [2:0] r);
        gexp_t g;
        m_src = pick(r, m_ptr);
        g.cyc = cyc + 1;
        g.src = m_src;
        gq.push_back(g);
        m_phase = 1;
    endtask

    // Predicts what the coming edge does, given the inputs just applied.
    task automatic model_step(input logic [2:0] r, input bit rdy);
        dexp_t d;
        case (m_phase)
            0: if (r != 3'b000) model_launch(r);
            1: begin
                d.cyc  = cyc + 1;
                d.data = src_data[m_src];
                dq.push_back(d);
                m_ptr   = (m_src + 1) % 3;
                m_phase = 2;
            end
            default: begin
                if (rdy) begin
                    if (r != 3'b000) model_launch(r);
                    else m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic step(input logic [2:0] r, input bit rdy, input logic [WIDTH-1:0] dx,
                        input logic [WIDTH-1:0] dy, input logic [WIDTH-1:0] dz);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req       = r;
        bus.out_ready = rdy;
        src_data[0]   = dx;
        src_data[1]   = dy;
        src_data[2]   = dz;
        model_step(r, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(3'b000, 1'b1, '0, '0, '0);
    endtask

    // Monitor: every cycle check output invariants, grants, new words and hold stability.
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] cur_data = '0;

    always @(posedge clk) begin
        gexp_t g;
        dexp_t d;
        #1;
        chk("sel_grant_consistent", 32'(bus.grant != 3'b000), 32'(bus.sel != 2'b11));
        if (bus.grant != 3'b000) begin
            if (gq.size() == 0) begin
                chk("unexpected_grant", 32'(bus.grant), 32'd0);
            end else begin
                g = gq.pop_front();
                chk("grant_cycle", 32'(cyc), 32'(g.cyc));
                chk("grant_onehot", 32'(bus.grant), 32'(3'b001 << g.src));
                chk("grant_sel", 32'(bus.sel), 32'(g.src));
            end
        end
        if (bus.out_valid && !prev_valid) begin
            if (dq.size() == 0) begin
                chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                d = dq.pop_front();
                chk("data_cycle", 32'(cyc), 32'(d.cyc));
                chk("data_value", 32'(bus.out_data), 32'(d.data));
                cur_data = d.data;
            end
        end else if (bus.out_valid) begin
            chk("data_hold", 32'(bus.out_data), 32'(cur_data));
        end
        prev_valid = bus.out_valid;
    end

    initial begin
        bus.req       = 3'b111;
        bus.out_ready = 1'b0;
        src_data[0]   = '0;
        src_data[1]   = '0;
        src_data[2]   = '0;
        model_reset();

        // Reset held with all requests up: outputs stay at reset values.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_sel", 32'(bus.sel), 32'h3);
            chk("rst_grant", 32'(bus.grant), 32'h0);
            chk("rst_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_data", 32'(bus.out_data), 32'h0);
        end

        // Single source Y.
        step(3'b010, 1'b1, 4'h0, 4'hA, 4'h0);
        step(3'b000, 1'b1, 4'h0, 4'hA, 4'h0);
        drain();

        // All requesting, continuous ready, source-dependent data.
        for (int i = 0; i < 12; i++) step(3'b111, 1'b1, 4'h1, 4'h2, 4'h3);
        drain();

        // Backpressure while Z keeps requesting and its data moves.
        step(3'b100, 1'b0, 4'h0, 4'h0, 4'h5);
        step(3'b100, 1'b0, 4'h0, 4'h0, 4'h5);
        for (int i = 0; i < 4; i++) step(3'b100, 1'b0, 4'h0, 4'h0, 4'(6 + i));
        step(3'b100, 1'b1, 4'h0, 4'h0, 4'hC);
        step(3'b000, 1'b1, 4'h0, 4'h0, 4'hC);
        drain();

        // X request dropped during its grant cycle, then all request.
        step(3'b001, 1'b1, 4'h7, 4'h0, 4'h0);
        step(3'b000, 1'b1, 4'h7, 4'h0, 4'h0);
        step(3'b000, 1'b1, 4'h7, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) step(3'b111, 1'b1, 4'h1, 4'h2, 4'h3);
        drain();

        // Randomized requests, readiness and data.
        for (int i = 0; i < 400; i++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end
        drain();

        // Reset while a word is held, then all request: X must win first.
        step(3'b110, 1'b0, 4'h1, 4'h2, 4'h3);
        step(3'b000, 1'b0, 4'h1, 4'h2, 4'h3);
        step(3'b000, 1'b0, 4'h1, 4'h2, 4'h3);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 3'b111;
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_sel", 32'(bus.sel), 32'h3);
        chk("midrst_grant", 32'(bus.grant), 32'h0);
        for (int i = 0; i < 6; i++) step(3'b111, 1'b1, 4'h1, 4'h2, 4'h3);
        drain();

        chk("grant_queue_empty", 32'(gq.size()), 32'd0);
        chk("data_queue_empty", 32'(dq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
